// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } uart_parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_STOP2,
        ST_WAIT_IDLE
    } uart_rx_state_e;

    localparam int UartMinDiv = 4;

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable bit-period down-counter; o_expire marks the terminal count of a loaded period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DivWidth = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic [DivWidth-1:0] i_load_val,
    output logic                o_expire
);

    logic [DivWidth-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Counter parks at zero after expiry, so a stale period never re-fires.
    assign o_expire = (r_cnt == DivWidth'(1));

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver with one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to build the PARITY state and parity checker.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int MaxDataBits = 8,
    parameter int DivWidth    = 16,
    parameter int SyncStages  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic [DivWidth-1:0]    i_div,
    input  logic [3:0]             i_nbits,
    input  logic [1:0]             i_parity,
    input  logic                   i_stop2,
    input  logic                   i_rx,
    output logic [MaxDataBits-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_frame_err,
    output logic                   o_parity_err,
    output logic                   o_break,
    output logic                   o_overrun,
    input  logic                   i_err_clr,
    output logic                   o_busy
);

    localparam logic [3:0] MinBits = 4'd5;
    localparam logic [3:0] MaxBits = 4'(MaxDataBits);

    uart_rx_state_e r_state;
    uart_rx_state_e w_state_nxt;

    logic [SyncStages-1:0]  r_sync;
    logic                   r_rx_d;
    logic [DivWidth-1:0]    r_div;
    logic [3:0]             r_nbits;
    logic                   r_stop2;
    logic [3:0]             r_bitcnt;
    logic [MaxDataBits-1:0] r_shift;
    logic                   r_ferr;
    logic [MaxDataBits-1:0] r_data;
    logic                   r_valid;
    logic                   r_ferr_out;
    logic                   r_perr_out;
    logic                   r_break;
    logic                   r_overrun;

    logic                   w_rx;
    logic                   w_fall;
    logic                   w_expire;
    logic                   w_load;
    logic [DivWidth-1:0]    w_load_val;
    logic                   w_done;
    logic [DivWidth-1:0]    w_div_eff;
    logic [3:0]             w_nbits_eff;
    logic                   w_frame_err;
    logic                   w_perr;
    logic                   w_par_zero;
    logic                   w_brk;
    uart_rx_state_e         w_after_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_rx_d <= 1'b0;
        end else begin
            r_sync[0] <= i_rx;
            for (int i = 1; i < SyncStages; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_rx_d <= w_rx;
        end
    end

    assign w_rx   = r_sync[SyncStages-1];
    assign w_fall = r_rx_d & ~w_rx;

    assign w_div_eff   = (i_div < DivWidth'(UartMinDiv)) ? DivWidth'(UartMinDiv) : i_div;
    assign w_nbits_eff = (i_nbits < MinBits) ? MinBits :
                         (i_nbits > MaxBits) ? MaxBits : i_nbits;

`ifdef UART_RX_PARITY_EN
    logic r_par_en;
    logic r_par_odd;
    logic r_par_bit;

    assign w_after_data = r_par_en ? ST_PARITY : ST_STOP;
    assign w_perr       = r_par_en & ((^r_shift ^ r_par_bit) != r_par_odd);
    assign w_par_zero   = ~r_par_en | ~r_par_bit;
`else
    logic w_unused_parity;

    assign w_unused_parity = ^i_parity;
    assign w_after_data    = ST_STOP;
    assign w_perr          = 1'b0;
    assign w_par_zero      = 1'b1;
`endif

    assign w_frame_err = r_ferr | ~w_rx;
    assign w_brk       = w_frame_err & (r_shift == '0) & w_par_zero;

    uart_baud_gen #(
        .DivWidth (DivWidth)
    ) u_baud_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = r_div;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = ST_START;
                    w_load      = 1'b1;
                    w_load_val  = w_div_eff >> 1;
                end
            end
            ST_START: begin
                if (w_expire) begin
                    if (w_rx) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA;
                        w_load      = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_expire) begin
                    w_load = 1'b1;
                    if (r_bitcnt == r_nbits - 4'd1) begin
                        w_state_nxt = w_after_data;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_expire) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_expire) begin
                    if (r_stop2) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_STOP2;
                    end else begin
                        w_done      = 1'b1;
                        w_state_nxt = w_rx ? ST_IDLE : ST_WAIT_IDLE;
                    end
                end
            end
            ST_STOP2: begin
                if (w_expire) begin
                    w_done      = 1'b1;
                    w_state_nxt = w_rx ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (w_rx) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Disable overrides everything: abort silently, holding register untouched.
        if (!i_en) begin
            w_state_nxt = ST_IDLE;
            w_load      = 1'b0;
            w_done      = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_div    <= '0;
            r_nbits  <= '0;
            r_stop2  <= 1'b0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_ferr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_par_bit <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_state_nxt == ST_START) begin
                r_div    <= w_div_eff;
                r_nbits  <= w_nbits_eff;
                r_stop2  <= i_stop2;
                r_bitcnt <= '0;
                r_shift  <= '0;
                r_ferr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_par_en  <= (i_parity == 2'(EVEN)) || (i_parity == 2'(ODD));
                r_par_odd <= (i_parity == 2'(ODD));
                r_par_bit <= 1'b0;
`endif
            end
            if (r_state == ST_DATA && w_expire) begin
                for (int i = 0; i < MaxDataBits; i++) begin
                    if (r_bitcnt == 4'(i)) begin
                        r_shift[i] <= w_rx;
                    end
                end
                r_bitcnt <= r_bitcnt + 4'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (r_state == ST_PARITY && w_expire) begin
                r_par_bit <= w_rx;
            end
`endif
            if (r_state == ST_STOP && w_expire) begin
                r_ferr <= ~w_rx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr_out <= 1'b0;
            r_perr_out <= 1'b0;
            r_break    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_break <= w_done & w_brk;
            if (w_done && (!r_valid || i_ready)) begin
                r_data     <= r_shift;
                r_valid    <= 1'b1;
                r_ferr_out <= w_frame_err;
                r_perr_out <= w_perr;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            if (w_done && r_valid && !i_ready) begin
                r_overrun <= 1'b1;
            end else if (i_err_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_frame_err  = r_ferr_out;
    assign o_parity_err = r_perr_out;
    assign o_break      = r_break;
    assign o_overrun    = r_overrun;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised, runtime-configurable UART receiver that supersedes the fixed 8N1 receive path and its fixed-divider prescaler. It provides a self-contained bit timer, selectable data width, parity and stop bits, false-start rejection, per-frame error flags, break detection and a one-entry valid/ready output register. It sits between the `i_rx` pin and the RX FIFO / bus interface of the `uart` top level.

## Interface
- `MaxDataBits`, default 8: width of `o_data`; legal range 5..9.
- `DivWidth`, default 16: width of `i_div`.
- `SyncStages`, default 2: number of flops in the `i_rx` synchroniser.
- `i_clk` input 1: system clock. This is the block's only clock.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_en` input 1: receiver enable. Deasserting it aborts the current frame.
- `i_div` input DivWidth: clocks per bit. Values below 4 are treated as 4.
- `i_nbits` input 4: data bits per frame, 5..MaxDataBits. The value is clamped into that range.
- `i_parity` input 2: parity mode. 0 = none, 1 = even, 2 = odd, 3 = none.
- `i_stop2` input 1: 1 selects two stop bits.
- `i_rx` input 1: asynchronous serial input. Idle state is high.
- `o_data` output MaxDataBits: received word, right-aligned, with unused upper bits at 0.
- `o_valid` output 1: the holding register contains a frame.
- `i_ready` input 1: the consumer accepts the frame.
- `o_frame_err` output 1: a stop bit was sampled low. Qualified by `o_valid`.
- `o_parity_err` output 1: parity mismatch. Qualified by `o_valid`.
- `o_break` output 1: one-cycle pulse when a break frame is detected.
- `o_overrun` output 1: sticky. A frame completed while `o_valid` was already high.
- `i_err_clr` input 1: clears `o_overrun`.
- `o_busy` output 1: the FSM is in any state other than IDLE.

## Operation
- The FSM has these states: IDLE, START, DATA, PARITY, STOP, STOP2, WAIT_IDLE.
- Configuration latching:
  - `i_div`, `i_nbits`, `i_parity` and `i_stop2` are latched on the IDLE→START transition.
  - Changes to these inputs during a frame are ignored.
- IDLE → START happens on a falling edge of the synchronised `rx`, provided `i_en`=1.
- START:
  - The bit timer loads `div/2`.
  - At expiry, `rx` is sampled. If it is 1 (false start), the FSM returns to IDLE. Otherwise it moves to DATA.
- DATA:
  - The timer reloads `div` for each bit.
  - Bits are sampled LSB first into a shift register, `nbits` samples in total.
  - After the last bit, the FSM goes to PARITY if parity is enabled, else to STOP.
- PARITY:
  - One bit is sampled.
  - The error condition is XOR(data bits, parity bit) ≠ (mode == odd).
- STOP:
  - One bit is sampled. A 0 sets the frame error.
  - If `i_stop2`=1 the FSM continues to STOP2, which checks a second stop bit the same way. A 0 there also sets the frame error.
- Frame completion:
  - On the last stop sample, the frame is completed: data and error flags are loaded into the holding register.
  - If the last stop sample was 0, the FSM goes to WAIT_IDLE. Otherwise it goes to IDLE.
- WAIT_IDLE waits until `rx`=1, then goes to IDLE.
- Break: all data bits 0, parity bit (if present) 0, and a frame error. The frame is still delivered, and `o_break` pulses.
- Holding register:
  - A handshake occurs when `o_valid`=1 and `i_ready`=1 in the same cycle; it clears `o_valid`.
  - When a frame completes while `o_valid`=1:
    - If `i_ready`=1 in that same cycle, the new frame is loaded and there is no overrun.
    - Otherwise, the new frame is dropped, the old data is held, and `o_overrun` is set.
- `i_err_clr` and a new overrun in the same cycle: the overrun wins and `o_overrun` stays 1.
- `i_en`=0 forces the FSM to IDLE on the next clock with no output. The holding register is unaffected.

## Timing
- Every output resets to 0; the FSM resets to IDLE and all counters to 0.
- Input latency: `SyncStages` cycles from the pin to the synchronised `rx`. The edge detector adds 1 more cycle.
- Let t be the cycle in which the synchronised falling edge is detected:
  - The start bit is sampled at t + div/2.
  - Data bit k is sampled at t + div/2 + (k+1)·div.
- `o_valid`, the error flags and `o_break` assert 1 cycle after the final stop sample.
- `o_busy` rises at t+1 and falls on the cycle of the return to IDLE.
- `o_overrun` sets 1 cycle after the dropped frame completes. It clears 1 cycle after `i_err_clr`.

## Configuration
- The macro is `UART_RX_PARITY_EN`.
- When it is defined: the PARITY state and the parity checker are built, and `i_parity` behaves as described under Operation.
- When it is undefined:
  - `i_parity` is ignored and parity is never sampled; frames are treated as no-parity.
  - `o_parity_err` is tied to 0.
  - Port list is unchanged.

## Structure
- `uart_pkg` holds:
  - the `uart_parity_e` enum (NONE, EVEN, ODD),
  - the `uart_rx_state_e` FSM enum,
  - `UartMinDiv` = 4.
- One sub-module, `uart_baud_gen`:
  - Loadable down-counter of width `DivWidth`.
  - Inputs: `load`, `load_val`.
  - Output: an `expire` strobe.
  - It replaces the fixed prescaler.

## Test plan
- 8N1, div=8, byte 0xA5 → `o_data`=0xA5, `o_valid` at the cycle given under Timing, no error flags.
- 8E1, byte 0x03 sent with parity bit 1 → `o_parity_err`=1 and `o_data`=0x03. The same test with the macro undefined gives `o_parity_err`=0 with 8N1 framing.
- 5N2, byte 0x15 with the second stop bit 0 → `o_data`=0x15 (upper bits 0) and `o_frame_err`=1. With `rx` then held low, no new frame starts until `rx` rises.
- Break (`rx` low for 12 bit times, 8N1) → `o_data`=0x00, `o_frame_err`=1, one `o_break` pulse, and exactly one frame delivered.
- Two frames, 0x11 then 0x22, with `i_ready`=0 → `o_data` stays 0x11 and `o_overrun`=1. Then pulse `i_ready` and `i_err_clr` → `o_valid`=0 and `o_overrun`=0.
- Low glitch of 2 cycles (div=16) → no frame is delivered and `o_busy` returns to 0. `i_rst_n` asserted in mid-DATA → all outputs are 0 immediately, and the next frame, 0x5A, is received correctly.
